rx_bit_sampler: RTL and testbench
=================================

RX_BIT_SAMPLER -- requirements
Module: rx_bit_sampler

Interface
REQ-001 Parameter PRESCALE_W, default 6: width of Prescale and Edge_cnt.
REQ-002 CLK  input  1  RX oversampling clock; all state on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 En  input  1  sampling enable from the RX FSM; high for the whole frame.
REQ-005 RX_IN  input  1  serial line, idle high.
REQ-006 Prescale  input  PRESCALE_W  oversampling ratio (legal: even, 4..32).
REQ-007 Sampled_bit  output  1  majority-voted bit value, feeds start/parity/stop checkers.
REQ-008 Sample_valid  output  1  one-cycle pulse when Sampled_bit is updated.
REQ-009 Bit_done  output  1  one-cycle pulse on the last edge of each bit period.
REQ-010 Edge_cnt  output  PRESCALE_W  current oversample index within the bit.
REQ-011 Bit_cnt  output  4  bit index within the frame (0 = start bit).

Function
REQ-012 Effective ratio P: equals Prescale when legal; illegal values (odd, <4, >32) SHALL be treated as P=8.
REQ-013 While En=1, Edge_cnt SHALL increment by 1 each cycle, 0..P-1, wrapping to 0 after P-1.
REQ-014 Sample points: RX_IN (post-sync when enabled) SHALL be captured at Edge_cnt = P/2-1 (s0) and P/2 (s1).
REQ-015 At Edge_cnt = P/2+1: Sampled_bit <= majority(s0, s1, RX_IN); Sample_valid SHALL be 1 in the following cycle only.
REQ-016 Bit_done SHALL be 1 in the cycle after the cycle where Edge_cnt = P-1.
REQ-017 Bit_cnt SHALL increment on each Edge_cnt wrap P-1 -> 0, saturating at 15.
REQ-018 States: IDLE (En=0) and SAMPLE (En=1); IDLE->SAMPLE on En rise, first counted edge (Edge_cnt=0) is the cycle En is first sampled high.
REQ-019 SAMPLE->IDLE on En fall, at any Edge_cnt: Edge_cnt, Bit_cnt, s0, s1 cleared next cycle; Sample_valid and Bit_done SHALL be 0; Sampled_bit holds its value.
REQ-020 En re-asserted in the cycle after deassertion SHALL restart at Edge_cnt=0, Bit_cnt=0 with no stale samples.
REQ-021 Prescale change while En=1 is undefined for the current bit; takes effect from the next Edge_cnt wrap or the next IDLE->SAMPLE entry.
REQ-022 Edge_cnt comparisons SHALL be done at PRESCALE_W bits; no truncation of P/2+1 for P=32 with PRESCALE_W=6.

Reset
REQ-023 RST=1 at a clock edge SHALL force: Edge_cnt=0, Bit_cnt=0, s0=s1=1, Sampled_bit=1, Sample_valid=0, Bit_done=0, synchronizer flops=1.
REQ-024 RST SHALL take priority over En; reset mid-bit discards all partial samples.

Configuration
REQ-025 Macro RX_SYNC_EN defined: RX_IN passes through a 2-flop synchronizer (reset value 1) before sampling; sample capture sees RX_IN delayed 2 cycles.
REQ-026 Macro RX_SYNC_EN undefined: RX_IN sampled directly; no extra latency; no synchronizer flops present.

Verification
REQ-027 P=8, RX_IN=0 for a full bit, En held high -> Sample_valid pulse after Edge_cnt=5, Sampled_bit=0; Bit_done after Edge_cnt=7; Bit_cnt 0->1.
REQ-028 P=16, RX_IN=1 except a 1-cycle 0 glitch at Edge_cnt=8 -> Sampled_bit=1 (majority 1,0,1).
REQ-029 P=32, 10 consecutive bits pattern 0,1,0,1,1,0,0,1,0,1 -> ten Sample_valid pulses with matching Sampled_bit; Bit_cnt ends at 10.
REQ-030 P=8, En dropped at Edge_cnt=3 and re-raised next cycle -> Edge_cnt=0, Bit_cnt=0, no Sample_valid until Edge_cnt=5 of new bit.
REQ-031 Prescale=7 (illegal) -> behaviour identical to P=8 (Sample_valid after Edge_cnt=5, wrap at 7).
REQ-032 RST asserted at Edge_cnt=4 with RX_IN=0, then released with En=1 -> all outputs at reset values, Sampled_bit=1, counting restarts from 0; with RX_SYNC_EN, 0 first seen at s0 two cycles later than without.

Source files
------------

// File: rtl/rx_bit_sampler.sv
// rx_bit_sampler: oversampling bit sampler for a UART-style receiver.
// Counts oversample edges within each bit period and takes a 3-point
// majority vote around the bit centre. It also reports the bit index within
// the frame and emits one-cycle valid/done pulses.
// Optional build macro: RX_SYNC_EN adds a 2-flop input synchronizer on RX_IN.
module rx_bit_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  En,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  Sampled_bit,
    output logic                  Sample_valid,
    output logic                  Bit_done,
    output logic [PRESCALE_W-1:0] Edge_cnt,
    output logic [3:0]            Bit_cnt
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SAMPLE = 1'b1
    } state_t;

    localparam logic [PRESCALE_W-1:0] P_DEFAULT = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] P_MIN     = PRESCALE_W'(4);
    localparam logic [PRESCALE_W-1:0] P_MAX     = PRESCALE_W'(32);
    localparam logic [PRESCALE_W-1:0] ONE       = PRESCALE_W'(1);

    state_t                  state_q, state_d;
    logic [PRESCALE_W-1:0]   p_q, p_d;
    logic [PRESCALE_W-1:0]   edge_d;
    logic [3:0]              bit_d;
    logic                    s0_q, s0_d;
    logic                    s1_q, s1_d;
    logic                    sbit_d;
    logic                    valid_d;
    logic                    done_d;
    logic                    rx_s;

`ifdef RX_SYNC_EN
    logic sync_q1, sync_q2;

    // Two-flop synchronizer; idles high like the line itself.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments keep every flop sampling the
        // pre-edge values, so sync_q2 really lags sync_q1 by one cycle.
        if (RST) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= RX_IN;
            sync_q2 <= sync_q1;
        end
    end

    assign rx_s = sync_q2;
`else
    assign rx_s = RX_IN;
`endif

    // Effective ratio: accepted only when even and within 4..32, else 8.
    // The ratio is latched at the start of each bit, so a mid-bit change of
    // Prescale only applies from the next wrap or the next frame entry.
    logic                  p_legal;
    logic                  bit_start;
    logic [PRESCALE_W-1:0] p_in_eff;
    logic [PRESCALE_W-1:0] p_cur;
    logic [PRESCALE_W-1:0] p_half;
    logic [PRESCALE_W-1:0] pt_s0, pt_s1, pt_vote, pt_last;

    assign p_legal   = ~Prescale[0] && (Prescale >= P_MIN) && (Prescale <= P_MAX);
    assign p_in_eff  = p_legal ? Prescale : P_DEFAULT;
    assign bit_start = (state_q == ST_IDLE) || (Edge_cnt == '0);
    assign p_cur     = bit_start ? p_in_eff : p_q;
    assign p_half    = p_cur >> 1;
    assign pt_s0     = p_half - ONE;
    assign pt_s1     = p_half;
    assign pt_vote   = p_half + ONE;
    assign pt_last   = p_cur - ONE;

    // Next-state, counter and sample logic.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_d = state_q;
        p_d     = p_q;
        edge_d  = Edge_cnt;
        bit_d   = Bit_cnt;
        s0_d    = s0_q;
        s1_d    = s1_q;
        sbit_d  = Sampled_bit;
        valid_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE:   if (En)  state_d = ST_SAMPLE;
            ST_SAMPLE: if (!En) state_d = ST_IDLE;
            default:            state_d = ST_IDLE;
        endcase

        if (En) begin
            p_d = p_cur;
            if (Edge_cnt == pt_last) begin
                edge_d = '0;
                bit_d  = (Bit_cnt == 4'hF) ? Bit_cnt : Bit_cnt + 4'd1;
                done_d = 1'b1;
            end else begin
                edge_d = Edge_cnt + ONE;
            end
            if (Edge_cnt == pt_s0) s0_d = rx_s;
            if (Edge_cnt == pt_s1) s1_d = rx_s;
            // With P=4 the vote point coincides with the last edge.
            if (Edge_cnt == pt_vote) begin
                sbit_d  = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
                valid_d = 1'b1;
            end
        end else begin
            // Leaving the frame drops partial samples; Sampled_bit holds.
            edge_d = '0;
            bit_d  = '0;
            s0_d   = 1'b1;
            s1_d   = 1'b1;
        end
    end

    // State register; reset overrides En and discards partial samples.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            p_q          <= P_DEFAULT;
            Edge_cnt     <= '0;
            Bit_cnt      <= '0;
            s0_q         <= 1'b1;
            s1_q         <= 1'b1;
            Sampled_bit  <= 1'b1;
            Sample_valid <= 1'b0;
            Bit_done     <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            Edge_cnt     <= edge_d;
            Bit_cnt      <= bit_d;
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            Sampled_bit  <= sbit_d;
            Sample_valid <= valid_d;
            Bit_done     <= done_d;
        end
    end

endmodule

// File: tb/tb_rx_bit_sampler.sv
// tb_rx_bit_sampler: directed vector table plus hand-written multi-bit
// sequences for rx_bit_sampler (default PRESCALE_W=6).
module tb_rx_bit_sampler;

`ifdef RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic       En;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       Sampled_bit;
    logic       Sample_valid;
    logic       Bit_done;
    logic [5:0] Edge_cnt;
    logic [3:0] Bit_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    rx_bit_sampler #(.PRESCALE_W(6)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .En           (En),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .Sampled_bit  (Sampled_bit),
        .Sample_valid (Sample_valid),
        .Bit_done     (Bit_done),
        .Edge_cnt     (Edge_cnt),
        .Bit_cnt      (Bit_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic       en;
        logic       rx;
        logic [5:0] pre;
        logic [5:0] e_edge;
        logic [3:0] e_bit;
        logic       e_sb;
        logic       e_v;
        logic       e_d;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic add(input logic rst, input logic en, input logic rx, input int pre,
                       input int e_edge, input int e_bit, input logic e_sb,
                       input logic e_v, input logic e_d);
        vec_t v;
        v.rst    = rst;
        v.en     = en;
        v.rx     = rx;
        v.pre    = 6'(pre);
        v.e_edge = 6'(e_edge);
        v.e_bit  = 4'(e_bit);
        v.e_sb   = e_sb;
        v.e_v    = e_v;
        v.e_d    = e_d;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        RST = 1'b1; En = 1'b0; RX_IN = 1'b1; Prescale = 6'd8;
        step();
        RST = 1'b0;
        step();
    endtask

    // Drive one full bit period of p cycles with En high. RX_IN is 'base'
    // except for edges flo..fhi, where it is inverted. Checks edge tracking,
    // the position of the valid/done pulses, the voted bit and Bit_cnt.
    task automatic run_bit(input int p, input logic base, input int flo, input int fhi,
                           input logic exp_bit, input int exp_bcnt, input string name);
        int   nv  = 0;
        int   nd  = 0;
        logic got = ~exp_bit;
        for (int k = 0; k < p; k++) begin
            check($sformatf("%s edge k=%0d", name, k), Edge_cnt, k);
            En       = 1'b1;
            Prescale = 6'(p);
            RX_IN    = (k >= flo && k <= fhi) ? ~base : base;
            step();
            if (Sample_valid) begin
                nv++;
                got = Sampled_bit;
                check($sformatf("%s valid_pos", name), k, p / 2 + 1);
            end
            if (Bit_done) begin
                nd++;
                check($sformatf("%s done_pos", name), k, p - 1);
            end
        end
        check($sformatf("%s valid_count", name), nv, 1);
        check($sformatf("%s sampled_bit", name), got, exp_bit);
        check($sformatf("%s done_count", name), nd, 1);
        check($sformatf("%s bit_cnt", name), Bit_cnt, exp_bcnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat;
        logic       post_exp;

        //   rst en rx pre  edge bit sb v  d
        add(1, 0, 1, 8,  0, 0, 1, 0, 0);   // reset values
        add(0, 0, 1, 8,  0, 0, 1, 0, 0);   // idle holds
        // P=8, RX_IN=0 for a whole bit
        add(0, 1, 0, 8,  1, 0, 1, 0, 0);
        add(0, 1, 0, 8,  2, 0, 1, 0, 0);
        add(0, 1, 0, 8,  3, 0, 1, 0, 0);
        add(0, 1, 0, 8,  4, 0, 1, 0, 0);
        add(0, 1, 0, 8,  5, 0, 1, 0, 0);
        add(0, 1, 0, 8,  6, 0, 0, 1, 0);   // vote at edge 5
        add(0, 1, 0, 8,  7, 0, 0, 0, 0);
        add(0, 1, 0, 8,  0, 1, 0, 0, 1);   // wrap after edge 7
        // Prescale=7 (illegal) behaves as 8, RX_IN=1
        for (int e = 1; e <= 5; e++) add(0, 1, 1, 7, e, 1, 0, 0, 0);
        add(0, 1, 1, 7,  6, 1, 1, 1, 0);
        add(0, 1, 1, 7,  7, 1, 1, 0, 0);
        add(0, 1, 1, 7,  0, 2, 1, 0, 1);
        // P=4: vote and wrap on the same edge
        add(0, 1, 0, 4,  1, 2, 1, 0, 0);
        add(0, 1, 0, 4,  2, 2, 1, 0, 0);
        add(0, 1, 0, 4,  3, 2, 1, 0, 0);
        add(0, 1, 0, 4,  0, 3, 0, 1, 1);
        // P=8, En dropped at edge 3 and re-raised the next cycle
        add(0, 1, 1, 8,  1, 3, 0, 0, 0);
        add(0, 1, 1, 8,  2, 3, 0, 0, 0);
        add(0, 1, 1, 8,  3, 3, 0, 0, 0);
        add(0, 0, 1, 8,  0, 0, 0, 0, 0);   // cleared, Sampled_bit holds
        for (int e = 1; e <= 5; e++) add(0, 1, 1, 8, e, 0, 0, 0, 0);
        add(0, 1, 1, 8,  6, 0, 1, 1, 0);

        RST = 1'b1; En = 1'b0; RX_IN = 1'b1; Prescale = 6'd8;
        foreach (vecs[i]) begin
            RST      = vecs[i].rst;
            En       = vecs[i].en;
            RX_IN    = vecs[i].rx;
            Prescale = vecs[i].pre;
            step();
            check($sformatf("vec%0d Edge_cnt", i),     Edge_cnt,     vecs[i].e_edge);
            check($sformatf("vec%0d Bit_cnt", i),      Bit_cnt,      vecs[i].e_bit);
            check($sformatf("vec%0d Sampled_bit", i),  Sampled_bit,  vecs[i].e_sb);
            check($sformatf("vec%0d Sample_valid", i), Sample_valid, vecs[i].e_v);
            check($sformatf("vec%0d Bit_done", i),     Bit_done,     vecs[i].e_d);
        end

        // P=16: a zero bit, then a one with a single-cycle glitch at the
        // centre sample (majority 1,0,1 -> 1).
        do_reset();
        run_bit(16, 1'b0, -1, -1, 1'b0, 1, "p16_zero");
        run_bit(16, 1'b1, 8 - SYNC_LAT, 8 - SYNC_LAT, 1'b1, 2, "p16_glitch");

        // P=32: ten consecutive bits 0,1,0,1,1,0,0,1,0,1 (bit 0 first).
        do_reset();
        pat = 10'b1010011010;
        for (int i = 0; i < 10; i++)
            run_bit(32, pat[i], -1, -1, pat[i], i + 1, $sformatf("p32_bit%0d", i));
        check("p32 final Bit_cnt", Bit_cnt, 10);

        // Bit_cnt saturates at 15 (P=4, all ones).
        for (int i = 0; i < 7; i++)
            run_bit(4, 1'b1, -1, -1, 1'b1, (11 + i > 15) ? 15 : 11 + i,
                    $sformatf("sat_bit%0d", i));

        // Reset mid-bit with RX_IN=0, reset asserted together with En.
        do_reset();
        run_bit(8, 1'b0, -1, -1, 1'b0, 1, "pre_rst");
        for (int k = 0; k < 4; k++) begin
            En = 1'b1; RX_IN = 1'b0; Prescale = 6'd8;
            step();
        end
        check("mid_rst edge before", Edge_cnt, 4);
        RST = 1'b1; En = 1'b1; RX_IN = 1'b0;
        step();
        check("mid_rst Edge_cnt",     Edge_cnt,     0);
        check("mid_rst Bit_cnt",      Bit_cnt,      0);
        check("mid_rst Sampled_bit",  Sampled_bit,  1);
        check("mid_rst Sample_valid", Sample_valid, 0);
        check("mid_rst Bit_done",     Bit_done,     0);
        RST = 1'b0;
        // RX_IN is 1 on edges 0..3 and 0 from edge 4: the direct path votes
        // (1,0,0) -> 0, the synchronized path sees the 0 two edges later and
        // votes (1,1,1) -> 1.
        post_exp = (SYNC_LAT != 0) ? 1'b1 : 1'b0;
        run_bit(8, 1'b0, 0, 3, post_exp, 1, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
